// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an adder-sum producer and the sum accumulator.
// The slave modport is the accumulator's view. The master modport is the producer/consumer side.
interface sum_accumulator_if #(
    parameter int SUM_W = 17,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  start, len, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder sums into a saturating total.
// The total is held on an output handshake until the consumer accepts it.
module sum_accumulator #(
    parameter int SUM_W = 17,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    sum_accumulator_if.slave acc_if
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    // One extra bit so that a carry out of the accumulator signals saturation.
    logic [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0] count_inc;

    assign sum_wide  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(acc_if.in_sum);
    assign count_inc = count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (acc_if.start) begin
                    len_d   = acc_if.len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (acc_if.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (acc_if.in_valid) begin
                    if (sum_wide[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_wide[ACC_W-1:0];
                    end
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_if.in_ready  = (state_q == ACCUM);
    assign acc_if.out_valid = (state_q == DONE);
    assign acc_if.busy      = (state_q != IDLE);
    assign acc_if.out_acc   = acc_q;
    assign acc_if.out_count = count_q;
    assign acc_if.out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised bench for sum_accumulator: a stimulus process queues expected results
// from a plain-arithmetic model, and a monitor checks each accepted output against them.
module tb_sum_accumulator;
    localparam int SUM_W = 17;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_accumulator_if #(.SUM_W(SUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    sum_accumulator #(.SUM_W(SUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc_if (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic [SUM_W-1:0] sums_a [0:255];

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: stability while held, and scoreboard compare on acceptance.
    logic             have_prev = 1'b0;
    logic [ACC_W-1:0] prev_acc;
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_ovf;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (have_prev) begin
                chk("hold_acc", bus.out_acc, prev_acc);
                chk("hold_count", bus.out_count, prev_cnt);
                chk("hold_ovf", bus.out_ovf, prev_ovf);
            end
            prev_acc  = bus.out_acc;
            prev_cnt  = bus.out_count;
            prev_ovf  = bus.out_ovf;
            have_prev = 1'b1;
            if (bus.out_ready) begin
                have_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("result acc=%0d count=%0d ovf=%0d (model acc=%0d count=%0d ovf=%0d)",
                             bus.out_acc, bus.out_count, bus.out_ovf, e.acc, e.cnt, e.ovf);
                    chk("out_acc", bus.out_acc, e.acc);
                    chk("out_count", bus.out_count, e.cnt);
                    chk("out_ovf", bus.out_ovf, e.ovf);
                end
            end
        end else begin
            have_prev = 1'b0;
        end
    end

    // One complete run: n sums from sums_a, random input gaps up to gap_max,
    // bp cycles of output backpressure, optional start pulse during ACCUM.
    task automatic run(input int n, input int gap_max, input int bp, input bit mid_start);
        longint total = 0;
        exp_t   e;
        for (int i = 0; i < n; i++) total += longint'(sums_a[i]);
        e.acc = (total > ACC_MAX) ? ACC_MAX : total;
        e.cnt = n;
        e.ovf = (total > ACC_MAX) ? 1 : 0;
        exp_q.push_back(e);

        bus.start = 1'b1;
        bus.len   = CNT_W'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = CNT_W'($urandom);
        if (n == 0) begin
            chk("len0_in_ready", bus.in_ready, 0);
            chk("len0_out_valid", bus.out_valid, 1);
        end else begin
            chk("start_to_ready", bus.in_ready, 1);
        end

        for (int i = 0; i < n; i++) begin
            bit ok = 1'b0;
            bit r;
            if (gap_max > 0) begin
                int g = $urandom_range(0, gap_max);
                bus.in_valid = 1'b0;
                bus.in_sum   = SUM_W'($urandom);
                for (int k = 0; k < g; k++) begin
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_sum   = sums_a[i];
            if (mid_start && i == 0) begin
                bus.start = 1'b1;
                bus.len   = CNT_W'(9);
            end
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                r = bus.in_ready;
                @(posedge clk); #1;
                if (r) begin
                    ok = 1'b1;
                    break;
                end
            end
            bus.start = 1'b0;
            if (!ok) chk("xfer_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        chk("done_latency", bus.out_valid, 1);

        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
        end
        chk("done_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_out_acc"}, bus.out_acc, 0);
        chk({tag, "_out_count"}, bus.out_count, 0);
        chk({tag, "_out_ovf"}, bus.out_ovf, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle_zero("reset");

        // in_valid while idle must not accumulate
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(999);
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("idle_ignore_acc", bus.out_acc, 0);
        chk("idle_ignore_cnt", bus.out_count, 0);

        // T1 basic
        sums_a[0] = 7; sums_a[1] = 92; sums_a[2] = 625;
        run(3, 0, 0, 1'b0);

        // T2 saturation
        for (int i = 0; i < 130; i++) sums_a[i] = SUM_W'(131070);
        run(130, 0, 0, 1'b0);

        // T3 gaps and backpressure
        sums_a[0] = 9500; sums_a[1] = 10000; sums_a[2] = 0; sums_a[3] = 1;
        run(4, 3, 5, 1'b0);

        // T4 zero length
        run(0, 0, 2, 1'b0);

        // T5 reset mid-run discards the partial result
        bus.start = 1'b1;
        bus.len   = CNT_W'(5);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(40000);
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle_zero("midrun_reset");
        sums_a[0] = 3;
        run(1, 0, 0, 1'b0);

        // T6 start ignored during ACCUM
        sums_a[0] = SUM_W'($urandom); sums_a[1] = SUM_W'($urandom);
        run(2, 0, 0, 1'b1);

        // Randomised runs, some biased towards saturation
        for (int r = 0; r < 16; r++) begin
            int n = $urandom_range(1, 40);
            bit big = (r % 4 == 3);
            if (big) n = $urandom_range(120, 200);
            for (int i = 0; i < n; i++)
                sums_a[i] = big ? SUM_W'($urandom_range(100000, 131071)) : SUM_W'($urandom);
            run(n, (r % 2 == 0) ? 2 : 0, $urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
